dot_mac_acc: RTL and testbench

Parametrised successor to the two-product 8-bit MAC. Multiplies `LANES` operand pairs per beat, reduces them through a registered adder tree and accumulates across beats into an `ACC_WIDTH` accumulator, with signed/unsigned mode, valid/ready handshakes on both sides and vector framing. It sits between operand fetch and the attention score/softmax path and produces one dot-product result per framed vector.

---
 rtl/dot_mac_acc.sv | 216 +++++++++++++++++++++
 tb/tb_dot_mac_acc.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dot_mac_acc.sv
// dot_mac_acc: LANES-wide multiply, registered adder tree, framed accumulate.
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_valid/in_ready        input beat handshake
//   a_vec, b_vec             packed lane operands (lane i at i*DATA_WIDTH)
//   signed_mode, first, last per-beat mode and vector framing
//   out_valid/out_ready      result handshake
//   out_data/out_ovf/out_beats  dot product, sticky overflow, beat count
// Config: define DOT_MAC_SAT_EN to saturate instead of wrapping on overflow.
module dot_mac_acc #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] a_vec,
  input  logic [LANES*DATA_WIDTH-1:0] b_vec,
  input  logic                        signed_mode,
  input  logic                        first,
  input  logic                        last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ACC_WIDTH-1:0]        out_data,
  output logic                        out_ovf,
  output logic [15:0]                 out_beats
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int SW = PW + $clog2(LANES);
  localparam int VW = LANES * DATA_WIDTH;

  localparam logic [ACC_WIDTH-1:0] SMAX =
    {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SMIN =
    {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic stall;

  // capture stage
  logic          v0, m0, f0, l0;
  logic [VW-1:0] a0, b0;

  // multiply stage
  logic                    v1, m1, f1, l1;
  logic [LANES-1:0][PW-1:0] p1;
  logic [LANES-1:0][PW-1:0] prod;

  // tree stage
  logic                 v2, m2, f2, l2;
  logic [ACC_WIDTH-1:0] sum2;
  logic [SW-1:0]        tsum;
  logic [ACC_WIDTH-1:0] text;

  // accumulate stage
  logic [ACC_WIDTH-1:0] acc;
  logic                 ovf;
  logic [15:0]          beats;
  logic [ACC_WIDTH-1:0] base;
  logic [ACC_WIDTH-1:0] nsum;
  logic [ACC_WIDTH-1:0] nacc;
  logic                 carry;
  logic                 wovf;
  logic                 nov;
  logic [15:0]          nbeats;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0 <= 1'b0;
      m0 <= 1'b0;
      f0 <= 1'b0;
      l0 <= 1'b0;
      a0 <= '0;
      b0 <= '0;
    end else if (!stall) begin
      v0 <= in_valid;
      m0 <= signed_mode;
      f0 <= first;
      l0 <= last;
      a0 <= a_vec;
      b0 <= b_vec;
    end
  end

  always_comb begin
    logic [PW-1:0] ax;
    logic [PW-1:0] bx;
    prod = '0;
    for (int i = 0; i < LANES; i++) begin
      ax = {{DATA_WIDTH{m0 & a0[i*DATA_WIDTH+DATA_WIDTH-1]}},
            a0[i*DATA_WIDTH +: DATA_WIDTH]};
      bx = {{DATA_WIDTH{m0 & b0[i*DATA_WIDTH+DATA_WIDTH-1]}},
            b0[i*DATA_WIDTH +: DATA_WIDTH]};
      prod[i] = ax * bx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      m1 <= 1'b0;
      f1 <= 1'b0;
      l1 <= 1'b0;
      p1 <= '0;
    end else if (!stall) begin
      v1 <= v0;
      m1 <= m0;
      f1 <= f0;
      l1 <= l0;
      p1 <= prod;
    end
  end

  always_comb begin
    tsum = '0;
    for (int i = 0; i < LANES; i++) begin
      tsum = tsum + {{(SW-PW){m1 & p1[i][PW-1]}}, p1[i]};
    end
    text = ACC_WIDTH'(tsum);
    for (int k = SW; k < ACC_WIDTH; k++) begin
      text[k] = m1 & tsum[SW-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2   <= 1'b0;
      m2   <= 1'b0;
      f2   <= 1'b0;
      l2   <= 1'b0;
      sum2 <= '0;
    end else if (!stall) begin
      v2   <= v1;
      m2   <= m1;
      f2   <= f1;
      l2   <= l1;
      sum2 <= text;
    end
  end

  // A first beat adds onto zero, so it can never overflow.
  always_comb begin
    base = f2 ? '0 : acc;
    {carry, nsum} = {1'b0, base} + {1'b0, sum2};
    if (m2) begin
      wovf = (base[ACC_WIDTH-1] == sum2[ACC_WIDTH-1]) &&
             (nsum[ACC_WIDTH-1] != base[ACC_WIDTH-1]);
    end else begin
      wovf = carry;
    end
`ifdef DOT_MAC_SAT_EN
    // once clamped, the value is frozen until the vector closes
    if (!f2 && ovf) begin
      nacc = acc;
    end else if (wovf) begin
      if (m2) begin
        nacc = base[ACC_WIDTH-1] ? SMIN : SMAX;
      end else begin
        nacc = '1;
      end
    end else begin
      nacc = nsum;
    end
`else
    nacc = nsum;
`endif
    nov = (!f2 && ovf) || wovf;
    if (f2) begin
      nbeats = 16'd1;
    end else if (beats == 16'hFFFF) begin
      nbeats = beats;
    end else begin
      nbeats = beats + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      ovf       <= 1'b0;
      beats     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_beats <= '0;
    end else if (!stall) begin
      out_valid <= v2 && l2;
      if (v2 && l2) begin
        out_data  <= nacc;
        out_ovf   <= nov;
        out_beats <= nbeats;
        acc       <= '0;
        ovf       <= 1'b0;
        beats     <= '0;
      end else if (v2) begin
        acc   <= nacc;
        ovf   <= nov;
        beats <= nbeats;
      end
    end
  end

`ifndef SYNTHESIS
  localparam logic [31:0] LANES_U = LANES;
  initial begin
    assert (LANES >= 2 && (LANES_U & (LANES_U - 1)) == 0);
    assert (ACC_WIDTH >= SW);
  end
`endif

endmodule

// File: tb/tb_dot_mac_acc.sv
// Directed bench for dot_mac_acc: one 32-bit and one 18-bit instance.
module tb_dot_mac_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv;
  logic        sel18;
  logic        iv32, iv18;
  logic        rdy32, rdy18;
  logic [31:0] a_vec, b_vec;
  logic        signed_mode, first, last;
  logic        out_ready;
  logic        ov32, ov18;
  logic [31:0] od32;
  logic [17:0] od18;
  logic        of32, of18;
  logic [15:0] ob32, ob18;

  int total = 0;
  int bad   = 0;
  int k;

  always #5 clk = ~clk;

  assign iv32 = iv & ~sel18;
  assign iv18 = iv & sel18;

  dot_mac_acc #(.DATA_WIDTH(8), .LANES(4), .ACC_WIDTH(32)) u32 (
    .clk(clk), .rst(rst),
    .in_valid(iv32), .in_ready(rdy32),
    .a_vec(a_vec), .b_vec(b_vec),
    .signed_mode(signed_mode), .first(first), .last(last),
    .out_valid(ov32), .out_ready(out_ready),
    .out_data(od32), .out_ovf(of32), .out_beats(ob32)
  );

  dot_mac_acc #(.DATA_WIDTH(8), .LANES(4), .ACC_WIDTH(18)) u18 (
    .clk(clk), .rst(rst),
    .in_valid(iv18), .in_ready(rdy18),
    .a_vec(a_vec), .b_vec(b_vec),
    .signed_mode(signed_mode), .first(first), .last(last),
    .out_valid(ov18), .out_ready(out_ready),
    .out_data(od18), .out_ovf(of18), .out_beats(ob18)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] b,
                      input logic s, input logic f, input logic l);
    @(negedge clk);
    a_vec       = a;
    b_vec       = b;
    signed_mode = s;
    first       = f;
    last        = l;
    iv          = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iv = 1'b0;
  endtask

  task automatic wait_out(input bit use18, output int n);
    logic v;
    n = 0;
    v = 1'b0;
    while (!v && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      v = use18 ? ov18 : ov32;
    end
    chk("out_valid_seen", {63'd0, v}, 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    iv = 1'b0;
    sel18 = 1'b0;
    out_ready = 1'b1;
    a_vec = '0;
    b_vec = '0;
    signed_mode = 1'b0;
    first = 1'b0;
    last = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_valid", {63'd0, ov32}, 64'd0);
    chk("rst_data", {32'd0, od32}, 64'd0);
    chk("rst_ready", {63'd0, rdy32}, 64'd1);
    chk("rst_ovf", {63'd0, of32}, 64'd0);
    chk("rst_beats", {48'd0, ob32}, 64'd0);

    // single unsigned beat: 1*5+2*6+3*7+4*8 = 70
    beat(32'h04030201, 32'h08070605, 1'b0, 1'b1, 1'b1);
    idle();
    wait_out(1'b0, k);
    chk("s1_lat", 64'(k), 64'd3);
    chk("s1_data", {32'd0, od32}, 64'd70);
    chk("s1_beats", {48'd0, ob32}, 64'd1);
    chk("s1_ovf", {63'd0, of32}, 64'd0);
    @(posedge clk);
    #1;
    chk("s1_clear", {63'd0, ov32}, 64'd0);

    // signed: (-1)*2*4 lanes = -8 per beat, 3 beats
    beat(32'hFFFFFFFF, 32'h02020202, 1'b1, 1'b1, 1'b0);
    beat(32'hFFFFFFFF, 32'h02020202, 1'b1, 1'b0, 1'b0);
    beat(32'hFFFFFFFF, 32'h02020202, 1'b1, 1'b0, 1'b1);
    idle();
    wait_out(1'b0, k);
    chk("sg_lat", 64'(k), 64'd3);
    chk("sg_data", {32'd0, od32}, 64'h0000_0000_FFFF_FFE8);
    chk("sg_beats", {48'd0, ob32}, 64'd3);
    chk("sg_ovf", {63'd0, of32}, 64'd0);

    // back-pressure: results 4 and 2*3*4 = 24
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    beat(32'h01010101, 32'h01010101, 1'b0, 1'b1, 1'b1);
    beat(32'h02020202, 32'h03030303, 1'b0, 1'b1, 1'b1);
    idle();
    wait_out(1'b0, k);
    chk("bp_d1", {32'd0, od32}, 64'd4);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_v", {63'd0, ov32}, 64'd1);
      chk("bp_hold_d", {32'd0, od32}, 64'd4);
      chk("bp_ready", {63'd0, rdy32}, 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_v2", {63'd0, ov32}, 64'd1);
    chk("bp_d2", {32'd0, od32}, 64'd24);
    chk("bp_b2", {48'd0, ob32}, 64'd1);
    @(posedge clk);
    #1;
    chk("bp_done", {63'd0, ov32}, 64'd0);

    // last without first accumulates onto zero
    beat(32'h01010101, 32'h01010101, 1'b0, 1'b0, 1'b1);
    idle();
    wait_out(1'b0, k);
    chk("nf_data", {32'd0, od32}, 64'd4);
    chk("nf_beats", {48'd0, ob32}, 64'd1);

    // reset mid-vector discards the partial token
    beat(32'h01010101, 32'h01010101, 1'b0, 1'b1, 1'b0);
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("rm_novalid", {63'd0, ov32}, 64'd0);
    end
    beat(32'h04030201, 32'h08070605, 1'b0, 1'b1, 1'b1);
    idle();
    wait_out(1'b0, k);
    chk("rm_data", {32'd0, od32}, 64'd70);
    chk("rm_beats", {48'd0, ob32}, 64'd1);
    chk("rm_ovf", {63'd0, of32}, 64'd0);

    // 18-bit unsigned overflow: 2 * 260100 = 520200
    sel18 = 1'b1;
    beat(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
    beat(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
    idle();
    wait_out(1'b1, k);
    chk("ov_lat", 64'(k), 64'd3);
`ifdef DOT_MAC_SAT_EN
    chk("ov_data", {46'd0, od18}, 64'h3FFFF);
`else
    chk("ov_data", {46'd0, od18}, 64'd258056);
`endif
    chk("ov_flag", {63'd0, of18}, 64'd1);
    chk("ov_beats", {48'd0, ob18}, 64'd2);
    chk("ov_other", {63'd0, ov32}, 64'd0);
    sel18 = 1'b0;

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
